// File: rtl/mesh_traffic_seq_if.sv
// Bus between the traffic sequencer, its controller and the mesh.
// Carries the sweep control, the PE configuration/finish-flag signals
// and the per-pattern result report.
interface mesh_traffic_seq_if #(
    parameter int CNT_W = 16
);
    // Sweep control
    logic               start;
    logic               abort;
    logic [7:0]         pattern_mask;

    // Finish flags coming back from the mesh
    logic [7:0]         pe_task_send_finish_flag;
    logic [7:0]         pe_task_receive_finish_flag;

    // PE configuration driven into the mesh
    logic [7:0]         pe_enable;
    logic [7:0]         pe_dbg_mode_wire;
    logic [7:0]         pe_flush_wire;
    logic [23:0]        pe_send_num_wire;
    logic [23:0]        pe_receive_num_wire;
    logic [31:0]        pe_rate_wire;
    logic [31:0]        pe_mode_wire;
    logic [191:0]       pe_dst_seq_wire;

    // Status and per-pattern results
    logic               busy;
    logic               done;
    logic               result_valid;
    logic [2:0]         result_pattern;
    logic [CNT_W-1:0]   result_cycles;
    logic               result_timeout;

    // Sequencer side
    modport master (
        input  start, abort, pattern_mask,
        input  pe_task_send_finish_flag, pe_task_receive_finish_flag,
        output pe_enable, pe_dbg_mode_wire, pe_flush_wire,
        output pe_send_num_wire, pe_receive_num_wire,
        output pe_rate_wire, pe_mode_wire, pe_dst_seq_wire,
        output busy, done, result_valid, result_pattern,
        output result_cycles, result_timeout
    );

    // Controller / mesh side
    modport slave (
        output start, abort, pattern_mask,
        output pe_task_send_finish_flag, pe_task_receive_finish_flag,
        input  pe_enable, pe_dbg_mode_wire, pe_flush_wire,
        input  pe_send_num_wire, pe_receive_num_wire,
        input  pe_rate_wire, pe_mode_wire, pe_dst_seq_wire,
        input  busy, done, result_valid, result_pattern,
        input  result_cycles, result_timeout
    );
endinterface

// File: rtl/mesh_traffic_seq.sv
// Synthetic traffic-pattern sequencer for the 8-PE mesh.
// On start it walks the selected patterns in ascending order; each one is
// loaded from a small ROM, flushed, run until every PE reports finished or
// the run counter hits TIMEOUT, and its latency is reported.
module mesh_traffic_seq #(
    parameter int FLUSH_CYC = 4,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 5000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mesh_traffic_seq_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_LOAD,
        S_FLUSH,
        S_RUN,
        S_REPORT,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [7:0]   dbg;
        logic [23:0]  send;
        logic [23:0]  recv;
        logic [31:0]  rate;
        logic [31:0]  mode;
        logic [191:0] dst;
    } cfg_t;

    localparam int               FL_W    = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC);
    localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Widen a list of eight 3-bit destinations (PE7 in the top digit) into
    // the mesh's 24-bit-per-PE destination bus.
    function automatic logic [191:0] expand_dst(input logic [23:0] d);
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[24*i +: 24] = {21'd0, d[3*i +: 3]};
        end
        return r;
    endfunction

    // Pattern ROM. Destination lists are written as octal digits PE7..PE0.
    function automatic cfg_t rom(input logic [2:0] p);
        cfg_t c;
        // NOTE: every field gets its default before the case, so no path
        // through the decode leaves a field unassigned (no latch inferred).
        c.dbg  = 8'hFF;
        c.send = 24'h249249;
        c.recv = 24'h249249;
        c.rate = 32'h0;
        c.mode = 32'h1111_1111;
        c.dst  = '0;
        case (p)
            3'd0: c.dst = expand_dst(24'o01234567);   // complement
            3'd1: c.dst = expand_dst(24'o73516240);   // reverse
            3'd2: c.dst = expand_dst(24'o73625140);   // rotation
            3'd3: c.dst = expand_dst(24'o75316420);   // shuffle
            3'd4: c.dst = expand_dst(24'o21076543);   // tornado
            3'd5: c.dst = expand_dst(24'o07654321);   // neighbor
            3'd6: begin                               // hotspot into PE0
                c.send = 24'h249248;
                c.recv = 24'h000007;
            end
            3'd7: begin                               // turn
                c.send = 24'hFFFFFF;
                c.recv = 24'hFFFFFF;
                c.mode = 32'h0;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t           state;
    logic [3:0]       idx;          // bit 3 set means the scan ran past pattern 7
    logic [7:0]       mask_q;
    logic [FL_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] run_cnt;
    cfg_t             cfg_next;

    logic flags_clear;
    logic flags_full;
    logic run_at_limit;

    assign flags_clear  = (bus.pe_task_send_finish_flag == 8'h00) &&
                          (bus.pe_task_receive_finish_flag == 8'h00);
    assign flags_full   = (bus.pe_task_send_finish_flag == 8'hFF) &&
                          (bus.pe_task_receive_finish_flag == 8'hFF);
    assign run_at_limit = (32'(run_cnt) >= 32'(TIMEOUT));
    assign cfg_next     = rom(idx[2:0]);

    // Sweep FSM with every output registered alongside the state.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= S_IDLE;
            idx                     <= '0;
            mask_q                  <= '0;
            flush_cnt               <= '0;
            run_cnt                 <= '0;
            bus.pe_enable           <= '0;
            bus.pe_dbg_mode_wire    <= '0;
            bus.pe_flush_wire       <= '0;
            bus.pe_send_num_wire    <= '0;
            bus.pe_receive_num_wire <= '0;
            bus.pe_rate_wire        <= '0;
            bus.pe_mode_wire        <= '0;
            bus.pe_dst_seq_wire     <= '0;
            bus.busy                <= 1'b0;
            bus.done                <= 1'b0;
            bus.result_valid        <= 1'b0;
            bus.result_pattern      <= '0;
            bus.result_cycles       <= '0;
            bus.result_timeout      <= 1'b0;
        end else if (bus.abort) begin
            // Abandon the sweep silently; configuration buses keep their value.
            state             <= S_IDLE;
            bus.pe_enable     <= '0;
            bus.pe_flush_wire <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.result_valid  <= 1'b0;
        end else begin
            bus.done         <= 1'b0;
            bus.result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mask_q   <= bus.pattern_mask;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (idx[3]) begin
                        bus.done <= 1'b1;
                        state    <= S_FIN;
                    end else if (mask_q[idx[2:0]]) begin
                        bus.pe_enable           <= '0;
                        bus.pe_dbg_mode_wire    <= cfg_next.dbg;
                        bus.pe_send_num_wire    <= cfg_next.send;
                        bus.pe_receive_num_wire <= cfg_next.recv;
                        bus.pe_rate_wire        <= cfg_next.rate;
                        bus.pe_mode_wire        <= cfg_next.mode;
                        bus.pe_dst_seq_wire     <= cfg_next.dst;
                        state                   <= S_LOAD;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_LOAD: begin
                    bus.pe_flush_wire <= 8'hFF;
                    flush_cnt         <= '0;
                    state             <= S_FLUSH;
                end
                S_FLUSH: begin
                    // Leave only once the minimum hold is met and the mesh is quiet.
                    if (flush_cnt == FL_LAST && flags_clear) begin
                        bus.pe_flush_wire <= '0;
                        bus.pe_enable     <= 8'hFF;
                        run_cnt           <= CNT_W'(1);
                        state             <= S_RUN;
                    end else if (flush_cnt != FL_LAST) begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // Completion is tested first so it wins a tie with timeout.
                    if (flags_full || run_at_limit) begin
                        bus.pe_enable      <= '0;
                        bus.result_valid   <= 1'b1;
                        bus.result_pattern <= idx[2:0];
                        bus.result_cycles  <= run_cnt;
                        bus.result_timeout <= ~flags_full;
                        state              <= S_REPORT;
                    end else if (run_cnt != CNT_MAX) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    idx   <= idx + 4'd1;
                    state <= S_SCAN;
                end
                S_FIN: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
